// File: rtl/knn_mean_sched.sv
// Running-mean filter sequencer: loads K entries, computes their mean, re-streams them with
// valid cleared where distance > mean. Entry layout {valid, id, distance}. Option: KNN_MEAN_EMA_EN.
module knn_mean_sched #(
   parameter int K    = 8,
   parameter int B    = 32,
   parameter int ID_W = 16,
   localparam int L   = $clog2(K),
   localparam int E_W = 1 + ID_W + B
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic           flush,
   input  logic [E_W-1:0] in_entry,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [E_W-1:0] out_entry,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic [B-1:0]   running_mean,
   output logic           running_mean_valid,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {IDLE, LOAD, MEAN, EMIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [L-1:0]     cnt_q, cnt_d;
   logic [B+L-1:0]   sum_q, sum_d;
   logic [L:0]       nvalid_q, nvalid_d;
   logic [B-1:0]     rm_q, rm_d;
   logic             rmv_q, rmv_d;
   logic             wr_en;
   logic [E_W-1:0]   ent_q [K];
   logic [B-1:0]     batch_mean, ema;
   logic [E_W-1:0]   cur;
   logic             keep;

   assign batch_mean = sum_q[B+L-1:L];

`ifdef KNN_MEAN_EMA_EN
   assign ema = rm_q - (rm_q >> 2) + (batch_mean >> 2);
`else
   assign ema = batch_mean;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      nvalid_d = nvalid_q;
      rm_d     = rm_q;
      rmv_d    = rmv_q;
      wr_en    = 1'b0;
      if (flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         sum_d    = '0;
         nvalid_d = '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_d  = LOAD;
               cnt_d    = '0;
               sum_d    = '0;
               nvalid_d = '0;
            end
            LOAD: if (in_valid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (in_entry[E_W-1]) begin
                  sum_d    = sum_q + {{L{1'b0}}, in_entry[B-1:0]};
                  nvalid_d = nvalid_q + 1'b1;
               end
               if (cnt_q == L'(K-1)) state_d = MEAN;
            end
            MEAN: begin
               // An all-invalid batch leaves the old mean in place but marks it unusable.
               if (nvalid_q == '0) begin
                  rmv_d = 1'b0;
               end else begin
                  rm_d  = rmv_q ? ema : batch_mean;
                  rmv_d = 1'b1;
               end
               cnt_d   = '0;
               state_d = EMIT;
            end
            EMIT: if (out_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == L'(K-1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sum_q    <= '0;
         nvalid_q <= '0;
         rm_q     <= '0;
         rmv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         nvalid_q <= nvalid_d;
         rm_q     <= rm_d;
         rmv_q    <= rmv_d;
      end
   end

   // Entry storage carries no reset; contents are only observed in EMIT after a full load.
   always_ff @(posedge clock) begin
      if (wr_en) ent_q[cnt_q] <= in_entry;
   end

   assign cur  = ent_q[cnt_q];
   assign keep = cur[E_W-1] & rmv_q & (cur[B-1:0] <= rm_q);

   assign in_ready           = (state_q == LOAD);
   assign out_valid          = (state_q == EMIT);
   assign out_last           = (state_q == EMIT) && (cnt_q == L'(K-1));
   assign out_entry          = (state_q == EMIT) ? {keep, cur[E_W-2:0]} : '0;
   assign busy               = (state_q != IDLE);
   assign done               = (state_q == DONE);
   assign running_mean       = rm_q;
   assign running_mean_valid = rmv_q;

endmodule
